// File: rtl/mpc_pkg.sv
// Shared definitions for the packet port arbiter: FSM state encoding,
// default geometry and an elaboration-time log2 helper.
package mpc_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int NPORT_DEF = 4;
    localparam int DW_DEF    = 32;
    localparam int CNT_W_DEF = 16;

    // Bits needed to index n items, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pkt_port_arbiter_if.sv
// Handshake bundle between NPORT packet sources, the arbiter and the cache
// writer. The arbiter sits on the slave modport; sources/sink on master.
interface pkt_port_arbiter_if
    import mpc_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int DW    = DW_DEF
);
    localparam int PW = clog2(NPORT);

    logic [NPORT-1:0]    i_sop;
    logic [NPORT-1:0]    i_vld;
    logic [NPORT*DW-1:0] i_data;
    logic [NPORT-1:0]    i_eop;
    logic [NPORT-1:0]    o_rdy;
    logic                o_sop;
    logic                o_vld;
    logic [DW-1:0]       o_data;
    logic                o_eop;
    logic [PW-1:0]       o_port;
    logic                i_rdy;

    modport slave (
        input  i_sop, i_vld, i_data, i_eop, i_rdy,
        output o_rdy, o_sop, o_vld, o_data, o_eop, o_port
    );

    modport master (
        output i_sop, i_vld, i_data, i_eop, i_rdy,
        input  o_rdy, o_sop, o_vld, o_data, o_eop, o_port
    );

endinterface

// File: rtl/pkt_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester strictly after `last`,
// wrapping, so the most recently served port has lowest priority.
module rr_pick
    import mpc_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int PW    = clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    last,
    output logic [PW-1:0]    gnt_idx,
    output logic             any
);

    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        logic [PW-1:0] idx_v;
        gnt_idx = '0;
        any     = 1'b0;
        idx_v   = '0;
        for (int i = NPORT; i >= 1; i--) begin
            idx_v = PW'((int'(last) + i) % NPORT);
            if (req[idx_v]) begin
                gnt_idx = idx_v;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_port_arbiter.sv
// Packet-granular round-robin arbiter merging NPORT sop/vld/eop streams into
// one registered output stream. Grant is held from sop to eop.
// Optional build macro ARB_STAT_EN adds per-port completed-packet counters;
// without it o_pkt_cnt is tied to zero.
//
// state    | meaning
// ARB_IDLE | no port granted; pick next sop requester, all o_rdy low
// ARB_BUSY | `grant` owns the output until its eop beat is accepted
module pkt_port_arbiter
    import mpc_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    pkt_port_arbiter_if.slave      bus,
    output logic                   o_err,
    output logic [NPORT*CNT_W-1:0] o_pkt_cnt
);

    localparam int PW = clog2(NPORT);

    arb_state_t       state, state_nxt;
    logic [PW-1:0]    grant, grant_nxt;
    logic [PW-1:0]    last_grant, last_nxt;
    logic             first, first_nxt;
    logic             err_nxt;
    logic [NPORT-1:0] rdy;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;

    logic             can_acc;
    logic             acc;
    logic             sel_sop;
    logic             sel_eop;
    logic [DW-1:0]    sel_data;

    rr_pick #(.NPORT(NPORT), .PW(PW)) u_pick (
        .req     (bus.i_vld & bus.i_sop),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Output register accepts a new beat whenever it is empty or draining.
    assign can_acc  = !bus.o_vld || bus.i_rdy;
    assign sel_sop  = bus.i_sop[grant];
    assign sel_eop  = bus.i_eop[grant];
    assign sel_data = bus.i_data[int'(grant)*DW +: DW];
    assign acc      = (state == ARB_BUSY) && bus.i_vld[grant] && can_acc;
    assign bus.o_rdy = rdy;

    // Next-state, grant bookkeeping, per-port ready and error detection.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last_grant;
        first_nxt = first;
        err_nxt   = 1'b0;
        rdy       = '0;
        case (state)
            ARB_IDLE: begin
                err_nxt = |(bus.i_vld & ~bus.i_sop);
                if (pick_any) begin
                    grant_nxt = pick_idx;
                    first_nxt = 1'b1;
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                rdy[grant] = can_acc;
                if (acc) begin
                    first_nxt = 1'b0;
                    err_nxt   = sel_sop && !first;
                    if (sel_eop) begin
                        last_nxt  = grant;
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // FSM state and grant registers; last_grant resets so port 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= PW'(NPORT - 1);
            first      <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_nxt;
            first      <= first_nxt;
            o_err      <= err_nxt;
        end
    end

    // Output stage: load on accept, drop valid once drained with nothing new.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_vld  <= 1'b0;
            bus.o_sop  <= 1'b0;
            bus.o_eop  <= 1'b0;
            bus.o_data <= '0;
            bus.o_port <= '0;
        end else if (acc) begin
            bus.o_vld  <= 1'b1;
            bus.o_sop  <= sel_sop;
            bus.o_eop  <= sel_eop;
            bus.o_data <= sel_data;
            bus.o_port <= grant;
        end else if (bus.i_rdy) begin
            bus.o_vld  <= 1'b0;
        end
    end

`ifdef ARB_STAT_EN
    logic [CNT_W-1:0] cnt [NPORT];

    // Count accepted eop beats per port, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NPORT; p++) cnt[p] <= '0;
        end else if (acc && sel_eop) begin
            cnt[grant] <= cnt[grant] + 1'b1;
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_cnt
        assign o_pkt_cnt[p*CNT_W +: CNT_W] = cnt[p];
    end
`else
    assign o_pkt_cnt = '0;
`endif

endmodule
